uart_rx_fifo: RTL
=================

# uart_rx_fifo

Parametrised UART receiver with a built-in receive FIFO, replacing the fixed 8N1 receive path inside the board top level. Serial frames on `uart_rxd` are deserialised, checked for framing (and optionally parity), and pushed into a show-ahead FIFO. The FIFO is drained by the register-access command parser, which reads register/value byte pairs at its own pace.

## Interface
Parameters:
- `CLK_HZ`, 50000000, system clock frequency in Hz.
- `BIT_RATE`, 115200, line bit rate in bits/s; `CYCLES_PER_BIT = CLK_HZ/BIT_RATE` (integer division).
- `PAYLOAD_BITS`, 8, data bits per frame, legal 5..9.
- `STOP_BITS`, 1, stop bits per frame, legal 1 or 2.
- `PARITY_ODD`, 0, 0 = even parity, 1 = odd parity (only used when parity is compiled in).
- `FIFO_DEPTH`, 16, FIFO entries, power of two, 2..256.

Ports:
- `clk` in 1: system clock, all logic on rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `uart_rxd` in 1: asynchronous serial input, idle high.
- `uart_rx_en` in 1: enables start-bit detection.
- `rd_en` in 1: pop request from the consumer.
- `rd_data` out `PAYLOAD_BITS`: head-of-FIFO byte.
- `rd_valid` out 1: FIFO not empty; `rd_data` is meaningful.
- `fifo_count` out `$clog2(FIFO_DEPTH)+1`: current occupancy.
- `framing_err` out 1: one-cycle pulse when a frame is dropped because a stop bit sampled 0.
- `overflow` out 1: one-cycle pulse when a good frame is dropped because the FIFO is full.
- `parity_err` out 1: one-cycle pulse when a frame is dropped because of a parity mismatch (tied 0 without `UART_RX_PARITY_EN`).

## Operation
- `uart_rxd` passes through a 2-flop synchroniser (reset value 1); all sampling uses the synchronised signal.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: when `uart_rx_en`=1 and a synchronised 1→0 edge is seen, go to START and clear the bit-cycle counter.
  - START: at count `CYCLES_PER_BIT/2`, if the line is still 0 go to DATA; otherwise return to IDLE as a glitch, with no error pulse.
  - DATA: sample each bit at its centre, one full bit apart, LSB first, into the shift register. After `PAYLOAD_BITS` samples, go to PARITY if compiled in, else STOP.
  - PARITY: sample one bit and compare it with the computed parity.
  - STOP: sample `STOP_BITS` centres.
- Checks, in priority order: any stop sample 0 → `framing_err`, otherwise parity mismatch → `parity_err`, otherwise the frame is good. Only one pulse is raised per frame. After the last stop sample the FSM returns to IDLE.
- `uart_rx_en` is only consulted in IDLE; a frame already in progress always completes.
- FIFO push happens for a good frame only. The push is accepted if not full, or if full and `rd_en && rd_valid` in the same cycle. Otherwise the frame is discarded and `overflow` pulses.
- FIFO pop: `rd_en && rd_valid`. `rd_en` when empty is ignored.
- Simultaneous push and pop leaves `fifo_count` unchanged; the pointers wrap modulo `FIFO_DEPTH`.

## Timing
- Reset (async assert; release on a clean clock edge): FSM to IDLE, pointers and count to 0, `rd_valid`=0, `rd_data`=0, all error pulses 0, synchroniser to 1.
- Reset mid-frame aborts the frame and empties the FIFO.
- The push occurs on the clock edge one cycle after the final stop-bit centre sample. `rd_valid` rises the cycle after the push.
- End-to-end latency from the line falling edge to `rd_valid`: 2 (synchroniser) + `CYCLES_PER_BIT/2` + `(PAYLOAD_BITS + parity + STOP_BITS)*CYCLES_PER_BIT` + 2 cycles, ±1 cycle.
- Show-ahead FIFO: `rd_data` is valid whenever `rd_valid`=1. After a pop, the next entry (or hold) appears on the following cycle.
- Error pulses are exactly one cycle wide and coincide with the cycle in which a push would have occurred.

## Configuration
- `UART_RX_PARITY_EN` defined: the PARITY state is present and the parity bit is expected after the data bits, with polarity set by `PARITY_ODD`. A mismatch drops the frame and pulses `parity_err`.
- Not defined: no parity bit is expected, the PARITY state is removed, and `parity_err` is tied 0.

## Test plan
Defaults: 50 MHz clock, 115200 baud, `CYCLES_PER_BIT`=434.
- Send 0xAA then 0x1F (8N1, no reads) → `fifo_count`=2, `rd_data`=0xAA; after one `rd_en`, `rd_data`=0x1F; after a second pop, `rd_valid`=0.
- Send 0x55 with the stop bit forced 0 → one `framing_err` pulse, `fifo_count` stays 0; a following 0x33 is received correctly.
- Drive a 100 ns low glitch on an idle line → no state change, no pulses, FIFO empty.
- Send 17 bytes 0x00..0x10 with no reads → the 17th produces one `overflow` pulse, `fifo_count`=16, and bytes 0x00..0x0F are read back in order.
- With `UART_RX_PARITY_EN` and even parity: send 0x07 with parity bit 1 → accepted; send 0x07 with parity bit 0 → `parity_err` pulse, not stored.
- Assert `reset` mid-DATA of a frame with 3 bytes queued → `fifo_count`=0 and `rd_valid`=0 immediately; a subsequent 0xC3 is received correctly.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// UART receiver (N data bits, 1/2 stop bits) feeding a show-ahead receive FIFO.
// Optional parity checking is compiled in with `define UART_RX_PARITY_EN.
module uart_rx_fifo #(
   parameter int CLK_HZ       = 50000000,
   parameter int BIT_RATE     = 115200,
   parameter int PAYLOAD_BITS = 8,
   parameter int STOP_BITS    = 1,
   parameter int PARITY_ODD   = 0,
   parameter int FIFO_DEPTH   = 16
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          uart_rxd,
   input  logic                          uart_rx_en,
   input  logic                          rd_en,
   output logic [PAYLOAD_BITS-1:0]       rd_data,
   output logic                          rd_valid,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          framing_err,
   output logic                          overflow,
   output logic                          parity_err
);

   localparam int CYCLES_PER_BIT = CLK_HZ / BIT_RATE;
   localparam int CW = $clog2(CYCLES_PER_BIT + 1);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [CW-1:0] HALF_CNT  = CW'(CYCLES_PER_BIT / 2);
   localparam logic [CW-1:0] FULL_CNT  = CW'(CYCLES_PER_BIT - 1);
   localparam logic [3:0]    LAST_DATA = 4'(PAYLOAD_BITS - 1);
   localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);
   localparam logic [AW:0]   DEPTH_CNT = (AW+1)'(FIFO_DEPTH);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_START  = 3'd1;
   localparam logic [2:0] S_DATA   = 3'd2;
   localparam logic [2:0] S_PARITY = 3'd3;
   localparam logic [2:0] S_STOP   = 3'd4;

   logic rxd_meta_q, rxd_meta_d;
   logic rxd_sync_q, rxd_sync_d;
   logic rxd_prev_q, rxd_prev_d;

   logic [2:0]              state_q, state_d;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic [3:0]              bit_idx_q, bit_idx_d;
   logic [PAYLOAD_BITS-1:0] shreg_q, shreg_d;
   logic                    stop_bad_q, stop_bad_d;
   logic                    par_bad_q, par_bad_d;
   logic                    done_q, done_d;
   logic                    bit_tick;

   logic [PAYLOAD_BITS-1:0] mem_q [FIFO_DEPTH];
   logic [AW-1:0]           wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]           rd_ptr_q, rd_ptr_d;
   logic [AW:0]             count_q, count_d;
   logic                    good, full, push, pop;

   always_comb begin
      rxd_meta_d = uart_rxd;
      rxd_sync_d = rxd_meta_q;
      rxd_prev_d = rxd_sync_q;
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q + CW'(1);
      bit_idx_d  = bit_idx_q;
      shreg_d    = shreg_q;
      stop_bad_d = stop_bad_q;
      par_bad_d  = par_bad_q;
      done_d     = 1'b0;
      bit_tick   = (cnt_q == FULL_CNT);
      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (uart_rx_en && rxd_prev_q && !rxd_sync_q) begin
               state_d    = S_START;
               bit_idx_d  = '0;
               stop_bad_d = 1'b0;
               par_bad_d  = 1'b0;
            end
         end
         S_START: begin
            // a start bit that is no longer low at its centre is a glitch
            if (cnt_q == HALF_CNT) begin
               cnt_d   = '0;
               state_d = rxd_sync_q ? S_IDLE : S_DATA;
            end
         end
         S_DATA: begin
            if (bit_tick) begin
               cnt_d     = '0;
               shreg_d   = {rxd_sync_q, shreg_q[PAYLOAD_BITS-1:1]};
               bit_idx_d = bit_idx_q + 4'd1;
               if (bit_idx_q == LAST_DATA) begin
                  bit_idx_d = '0;
`ifdef UART_RX_PARITY_EN
                  state_d = S_PARITY;
`else
                  state_d = S_STOP;
`endif
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         S_PARITY: begin
            if (bit_tick) begin
               cnt_d     = '0;
               par_bad_d = rxd_sync_q != ((^shreg_q) ^ PARITY_ODD[0]);
               state_d   = S_STOP;
            end
         end
`endif
         S_STOP: begin
            if (bit_tick) begin
               cnt_d     = '0;
               bit_idx_d = bit_idx_q + 4'd1;
               if (!rxd_sync_q) stop_bad_d = 1'b1;
               if (bit_idx_q == LAST_STOP) begin
                  state_d = S_IDLE;
                  done_d  = 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Frame verdict is registered, so push and error pulses land one cycle after the last stop sample
   assign good        = done_q && !stop_bad_q && !par_bad_q;
   assign framing_err = done_q && stop_bad_q;
`ifdef UART_RX_PARITY_EN
   assign parity_err  = done_q && !stop_bad_q && par_bad_q;
`else
   assign parity_err  = 1'b0;
`endif

   assign rd_valid   = (count_q != '0);
   assign full       = (count_q == DEPTH_CNT);
   assign pop        = rd_en && rd_valid;
   assign push       = good && (!full || pop);
   assign overflow   = good && full && !pop;
   assign fifo_count = count_q;
   assign rd_data    = rd_valid ? mem_q[rd_ptr_q] : '0;

   always_comb begin
      wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
      case ({push, pop})
         2'b10:   count_d = count_q + (AW+1)'(1);
         2'b01:   count_d = count_q - (AW+1)'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rxd_meta_q <= 1'b1;
         rxd_sync_q <= 1'b1;
         rxd_prev_q <= 1'b1;
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         bit_idx_q  <= '0;
         shreg_q    <= '0;
         stop_bad_q <= 1'b0;
         par_bad_q  <= 1'b0;
         done_q     <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
      end else begin
         rxd_meta_q <= rxd_meta_d;
         rxd_sync_q <= rxd_sync_d;
         rxd_prev_q <= rxd_prev_d;
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         bit_idx_q  <= bit_idx_d;
         shreg_q    <= shreg_d;
         stop_bad_q <= stop_bad_d;
         par_bad_q  <= par_bad_d;
         done_q     <= done_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
      end
   end

   // Storage needs no reset: nothing is visible until count_q says so
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= shreg_q;
   end

endmodule
